link_pulse_monitor: RTL and testbench
=====================================

Name: link_pulse_monitor

Overview:
- Consumes the single-cycle rising-edge strobe from the per-port edge/level detector on the twisted-pair receive path.
- Checks 10BASE-T normal-link-pulse (NLP) spacing and declares link up/down per port.
- Drives the port link-status register and the MAC enable logic.
- Interval measurement uses a cycle counter compared against a programmable acceptance window.

Parameters:
- INTERVAL_MIN, 1000000, minimum accepted pulse spacing in clock cycles (8 ms at 125 MHz).
- INTERVAL_MAX, 3000000, maximum accepted spacing in cycles (24 ms); also the loss-of-link timeout.
- GOOD_PULSES, 3, consecutive in-window pulses needed to declare link up (legal range 1..15).
- CNT_W, $clog2(INTERVAL_MAX+2), gap counter width (derived; do not override).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  port enable; low forces IDLE synchronously.
- pulse  input  1  single-cycle pulse strobe from the edge detector.
- link_up  output  1  registered link status.
- link_change  output  1  one-cycle strobe on every link_up toggle.
- interval_error  output  1  one-cycle strobe when a pulse arrives early (gap < INTERVAL_MIN).
- pulse_count  output  16  saturating count of accepted in-window pulses.
- error_count  output  16  saturating count of early pulses plus timeouts (optional feature).

Behaviour:
- Reset (reset_n=0, async): state=IDLE, gap_cnt=0, good_cnt=0.
- All outputs are 0 during and after reset. Release is synchronous to clock.
- gap_cnt:
  - Set to 1 on any cycle with pulse=1.
  - Otherwise increments each cycle, saturating at INTERVAL_MAX+1.
  - At a pulse cycle, gap_cnt equals the cycle distance since the previous pulse.
- In-window pulse: INTERVAL_MIN <= gap_cnt <= INTERVAL_MAX (both bounds inclusive).
- States: IDLE, ACQUIRE, UP. All outputs are registered, so each takes effect one cycle after the deciding input.
- IDLE:
  - Pulse -> ACQUIRE, good_cnt=0.
  - No gap check on the first pulse.
- ACQUIRE:
  - In-window pulse: good_cnt+1 and pulse_count+1. If good_cnt+1 == GOOD_PULSES -> UP, link_up=1, link_change=1.
  - Early pulse: good_cnt=0, interval_error=1, stay in ACQUIRE.
  - No pulse with gap_cnt==INTERVAL_MAX -> IDLE (timeout).
- UP:
  - In-window pulse: pulse_count+1, stay in UP.
  - Early pulse: interval_error=1 -> ACQUIRE, good_cnt=0, link_up=0, link_change=1.
  - No pulse with gap_cnt==INTERVAL_MAX -> IDLE, link_up=0, link_change=1.
- Precedence: a pulse at gap_cnt==INTERVAL_MAX is in-window and beats timeout. enable=0 beats everything.
- enable=0:
  - Next state IDLE, good_cnt=0.
  - If link_up was 1, it clears with link_change=1.
  - pulse is ignored; gap_cnt is still tracked.
- link_change and interval_error are high for exactly one cycle per event, never for two consecutive cycles from one event.
- pulse_count and error_count saturate at 16'hFFFF. They are cleared only by reset_n.
- Pulses on consecutive cycles are legal input: the second sees gap_cnt=1, which is early.

Optional Feature:
- LINK_PULSE_STATS_EN defined:
  - error_count increments (saturating) on each interval_error strobe.
  - It also increments on each timeout from ACQUIRE or UP.
  - A timeout and an early pulse cannot coincide.
- Not defined: error_count is tied to 0 and its counter logic is not synthesized. Port list is unchanged.

Test Plan:
- Parameters for all scenarios: INTERVAL_MIN=8, INTERVAL_MAX=24, GOOD_PULSES=3.
- Reset: assert reset_n=0 mid-stream with link up -> all outputs 0 immediately; after release, pulses spaced 16 are needed again (4 pulses) before link_up=1.
- Acquire: pulses at cycles 0,16,32,48 -> link_up=1 and link_change=1 at cycle 49; link_change=0 at cycle 50; pulse_count=3.
- Timeout: from UP with last pulse at t -> link_up=0 and link_change=1 at t+25; pulse at t+24 instead keeps link_up=1 and pulse_count increments.
- Window edges: in ACQUIRE, gap 8 accepted; gap 24 accepted; gap 7 gives interval_error=1 for one cycle and good_cnt=0. Stats build: error_count=1.
- Early pulse in UP: gap 5 -> link_up=0, link_change=1, interval_error=1 in the same cycle; 3 further gaps of 16 restore link_up=1.
- Enable: drop enable for 1 cycle while UP -> link_up=0 with a single link_change; pulses during enable=0 do not change pulse_count.

Source files
------------

// File: rtl/link_pulse_monitor.sv
// 10BASE-T normal-link-pulse monitor: qualifies pulse spacing against a window and reports link state.
// Define LINK_PULSE_STATS_EN to build the error_count statistics counter; otherwise it reads as zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no link; waiting for the first pulse (spacing unchecked)
// ACQUIRE | counting consecutive in-window pulses toward link up
// UP      | link declared; every pulse must stay inside the window
module link_pulse_monitor #(
  parameter int unsigned INTERVAL_MIN = 1000000,
  parameter int unsigned INTERVAL_MAX = 3000000,
  parameter int unsigned GOOD_PULSES  = 3,
  parameter int unsigned CNT_W        = $clog2(INTERVAL_MAX + 2)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pulse,
  output logic        link_up,
  output logic        link_change,
  output logic        interval_error,
  output logic [15:0] pulse_count,
  output logic [15:0] error_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(INTERVAL_MIN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(INTERVAL_MAX);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(INTERVAL_MAX + 1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [3:0]       GOOD_C = 4'(GOOD_PULSES);

  state_t           state;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       good_cnt;
  logic             early;
  logic             in_window;
  logic             timeout;
  logic             checking;

  // gap_cnt holds the distance to the previous pulse when the next one arrives
  assign early     = pulse && (gap_cnt < MIN_C);
  assign in_window = pulse && (gap_cnt >= MIN_C) && (gap_cnt <= MAX_C);
  assign timeout   = !pulse && (gap_cnt == MAX_C);
  assign checking  = enable && (state != IDLE);

  // Tracked regardless of enable so spacing stays valid across a re-enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (pulse) begin
      gap_cnt <= ONE_C;
    end else if (gap_cnt != SAT_C) begin
      gap_cnt <= gap_cnt + ONE_C;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      good_cnt       <= 4'd0;
      link_up        <= 1'b0;
      link_change    <= 1'b0;
      interval_error <= 1'b0;
    end else begin
      link_change    <= 1'b0;
      interval_error <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        good_cnt <= 4'd0;
        if (link_up) begin
          link_up     <= 1'b0;
          link_change <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (pulse) begin
              state    <= ACQUIRE;
              good_cnt <= 4'd0;
            end
          end
          ACQUIRE: begin
            if (in_window) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == GOOD_C) begin
                state       <= UP;
                link_up     <= 1'b1;
                link_change <= 1'b1;
              end
            end else if (early) begin
              good_cnt       <= 4'd0;
              interval_error <= 1'b1;
            end else if (timeout) begin
              state    <= IDLE;
              good_cnt <= 4'd0;
            end
          end
          UP: begin
            if (early) begin
              state          <= ACQUIRE;
              good_cnt       <= 4'd0;
              interval_error <= 1'b1;
              link_up        <= 1'b0;
              link_change    <= 1'b1;
            end else if (timeout) begin
              state       <= IDLE;
              good_cnt    <= 4'd0;
              link_up     <= 1'b0;
              link_change <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            good_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulse_count <= 16'h0000;
    end else if (checking && in_window && (pulse_count != 16'hFFFF)) begin
      pulse_count <= pulse_count + 16'd1;
    end
  end

`ifdef LINK_PULSE_STATS_EN
  logic err_inc;

  // Early pulses and timeouts are mutually exclusive, so one increment per cycle suffices
  assign err_inc = checking && (early || timeout);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_count <= 16'h0000;
    end else if (err_inc && (error_count != 16'hFFFF)) begin
      error_count <= error_count + 16'd1;
    end
  end
`else
  assign error_count = 16'h0000;
`endif

endmodule

// File: tb/tb_link_pulse_monitor.sv
// Bench for link_pulse_monitor: directed scenarios plus randomized pulse trains against a timestamp-based model.
module tb_link_pulse_monitor;

  localparam int MIN  = 8;
  localparam int MAX  = 24;
  localparam int GOOD = 3;
`ifdef LINK_PULSE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_UP   = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pulse = 1'b0;
  logic        link_up;
  logic        link_change;
  logic        interval_error;
  logic [15:0] pulse_count;
  logic [15:0] error_count;

  int errors = 0;
  int checks = 0;

  // reference model: link mode plus timestamp of the last pulse
  int n, last, mode, streak, m_pc, m_ec;
  bit fresh, m_link, m_lc, m_ie;

  link_pulse_monitor #(
    .INTERVAL_MIN(MIN),
    .INTERVAL_MAX(MAX),
    .GOOD_PULSES (GOOD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .pulse         (pulse),
    .link_up       (link_up),
    .link_change   (link_change),
    .interval_error(interval_error),
    .pulse_count   (pulse_count),
    .error_count   (error_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mode = M_IDLE; streak = 0; m_pc = 0; m_ec = 0;
    m_link = 0; m_lc = 0; m_ie = 0; fresh = 1; n = 0; last = 0;
  endtask

  task automatic model_edge(input bit en, input bit p);
    int gap;
    if (fresh) begin
      last = n;
      fresh = 0;
    end
    gap = n - last;
    if (gap > MAX + 1) gap = MAX + 1;
    m_lc = 0;
    m_ie = 0;
    if (!en) begin
      mode = M_IDLE;
      if (m_link) begin m_link = 0; m_lc = 1; end
    end else if (mode == M_IDLE) begin
      if (p) begin mode = M_ACQ; streak = 0; end
    end else if (p && gap >= MIN && gap <= MAX) begin
      if (m_pc < 65535) m_pc++;
      if (mode == M_ACQ) begin
        streak++;
        if (streak == GOOD) begin mode = M_UP; m_link = 1; m_lc = 1; end
      end
    end else if (p && gap < MIN) begin
      m_ie = 1;
      if (STATS && m_ec < 65535) m_ec++;
      streak = 0;
      if (mode == M_UP) begin mode = M_ACQ; m_link = 0; m_lc = 1; end
    end else if (!p && gap == MAX) begin
      if (STATS && m_ec < 65535) m_ec++;
      if (m_link) begin m_link = 0; m_lc = 1; end
      mode = M_IDLE;
    end
    if (p) last = n;
    n++;
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step(input bit en, input bit p);
    enable = en;
    pulse  = p;
    @(posedge clock);
    model_edge(en, p);
    @(negedge clock);
  endtask

  task automatic pulse_gap(input int g);
    repeat (g - 1) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    pulse   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic bring_up();
    do_reset();
    step(1'b1, 1'b1);
    repeat (3) pulse_gap(16);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %0b expected 0", link_up); end
    checks++; if (link_change !== 1'b0) begin errors++; $display("FAIL reset_link_change: got %0b expected 0", link_change); end
    checks++; if (interval_error !== 1'b0) begin errors++; $display("FAIL reset_interval_error: got %0b expected 0", interval_error); end
    checks++; if (pulse_count !== 16'd0) begin errors++; $display("FAIL reset_pulse_count: got %0d expected 0", pulse_count); end
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL reset_error_count: got %0d expected 0", error_count); end
    bring_up();
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL reset_pre_up: got %0b expected 1", link_up); end
    reset_n = 1'b0;
    #1;
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_async_link_up: got %0b expected 0", link_up); end
    checks++; if (pulse_count !== 16'd0) begin errors++; $display("FAIL reset_async_pulse_count: got %0d expected 0", pulse_count); end
    checks++; if (link_change !== 1'b0) begin errors++; $display("FAIL reset_async_link_change: got %0b expected 0", link_change); end
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    step(1'b1, 1'b1);
    pulse_gap(16);
    pulse_gap(16);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_reacq_early_up: got %0b expected 0", link_up); end
    pulse_gap(16);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL reset_reacq_up: got %0b expected 1", link_up); end
  endtask

  task automatic test_acquire();
    do_reset();
    step(1'b1, 1'b1);
    pulse_gap(16);
    pulse_gap(16);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL acquire_not_yet: got %0b expected 0", link_up); end
    pulse_gap(16);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL acquire_link_up: got %0b expected 1", link_up); end
    checks++; if (link_change !== 1'b1) begin errors++; $display("FAIL acquire_link_change: got %0b expected 1", link_change); end
    checks++; if (pulse_count !== 16'd3) begin errors++; $display("FAIL acquire_pulse_count: got %0d expected 3", pulse_count); end
    step(1'b1, 1'b0);
    checks++; if (link_change !== 1'b0) begin errors++; $display("FAIL acquire_change_clear: got %0b expected 0", link_change); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL acquire_hold: got %0b expected 1", link_up); end
  endtask

  task automatic test_timeout();
    bring_up();
    repeat (23) step(1'b1, 1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_before: got %0b expected 1", link_up); end
    step(1'b1, 1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL timeout_link_up: got %0b expected 0", link_up); end
    checks++; if (link_change !== 1'b1) begin errors++; $display("FAIL timeout_link_change: got %0b expected 1", link_change); end
    checks++; if (error_count !== 16'(STATS ? 1 : 0)) begin errors++; $display("FAIL timeout_error_count: got %0d expected %0d", error_count, STATS ? 1 : 0); end
    bring_up();
    pulse_gap(24);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_edge_up: got %0b expected 1", link_up); end
    checks++; if (link_change !== 1'b0) begin errors++; $display("FAIL timeout_edge_change: got %0b expected 0", link_change); end
    checks++; if (pulse_count !== 16'd4) begin errors++; $display("FAIL timeout_edge_count: got %0d expected 4", pulse_count); end
    step(1'b1, 1'b0);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_edge_hold: got %0b expected 1", link_up); end
  endtask

  task automatic test_window_edges();
    do_reset();
    step(1'b1, 1'b1);
    pulse_gap(8);
    checks++; if (pulse_count !== 16'd1) begin errors++; $display("FAIL window_gap8: got %0d expected 1", pulse_count); end
    checks++; if (interval_error !== 1'b0) begin errors++; $display("FAIL window_gap8_err: got %0b expected 0", interval_error); end
    pulse_gap(24);
    checks++; if (pulse_count !== 16'd2) begin errors++; $display("FAIL window_gap24: got %0d expected 2", pulse_count); end
    pulse_gap(7);
    checks++; if (interval_error !== 1'b1) begin errors++; $display("FAIL window_gap7_err: got %0b expected 1", interval_error); end
    checks++; if (pulse_count !== 16'd2) begin errors++; $display("FAIL window_gap7_count: got %0d expected 2", pulse_count); end
    checks++; if (error_count !== 16'(STATS ? 1 : 0)) begin errors++; $display("FAIL window_error_count: got %0d expected %0d", error_count, STATS ? 1 : 0); end
    step(1'b1, 1'b0);
    checks++; if (interval_error !== 1'b0) begin errors++; $display("FAIL window_err_clear: got %0b expected 0", interval_error); end
    pulse_gap(15);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL window_good_cleared: got %0b expected 0", link_up); end
    pulse_gap(16);
    pulse_gap(16);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL window_reacquire: got %0b expected 1", link_up); end
  endtask

  task automatic test_early_up();
    bring_up();
    pulse_gap(5);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL early_link_up: got %0b expected 0", link_up); end
    checks++; if (link_change !== 1'b1) begin errors++; $display("FAIL early_link_change: got %0b expected 1", link_change); end
    checks++; if (interval_error !== 1'b1) begin errors++; $display("FAIL early_interval_error: got %0b expected 1", interval_error); end
    step(1'b1, 1'b0);
    checks++; if (link_change !== 1'b0 || interval_error !== 1'b0) begin errors++; $display("FAIL early_strobe_clear: got %0b%0b expected 00", link_change, interval_error); end
    pulse_gap(15);
    pulse_gap(16);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL early_partial: got %0b expected 0", link_up); end
    pulse_gap(16);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL early_restore: got %0b expected 1", link_up); end
    checks++; if (pulse_count !== 16'd6) begin errors++; $display("FAIL early_pulse_count: got %0d expected 6", pulse_count); end
  endtask

  task automatic test_enable();
    bring_up();
    step(1'b0, 1'b0);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL enable_link_up: got %0b expected 0", link_up); end
    checks++; if (link_change !== 1'b1) begin errors++; $display("FAIL enable_link_change: got %0b expected 1", link_change); end
    step(1'b1, 1'b0);
    checks++; if (link_change !== 1'b0) begin errors++; $display("FAIL enable_single_change: got %0b expected 0", link_change); end
    repeat (3) begin
      step(1'b0, 1'b0);
      repeat (15) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    checks++; if (pulse_count !== 16'd3) begin errors++; $display("FAIL enable_ignored_pulses: got %0d expected 3", pulse_count); end
    checks++; if (link_change !== 1'b0 || link_up !== 1'b0) begin errors++; $display("FAIL enable_quiet: got %0b%0b expected 00", link_change, link_up); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++; if (interval_error !== 1'b1) begin errors++; $display("FAIL b2b_first_err: got %0b expected 1", interval_error); end
    step(1'b1, 1'b0);
    checks++; if (interval_error !== 1'b0) begin errors++; $display("FAIL b2b_err_clear: got %0b expected 0", interval_error); end
    checks++; if (error_count !== 16'(STATS ? 1 : 0)) begin errors++; $display("FAIL b2b_error_count: got %0d expected %0d", error_count, STATS ? 1 : 0); end
  endtask

  task automatic test_random();
    int to_next;
    bit en, p;
    do_reset();
    to_next = $urandom_range(1, 30);
    for (int i = 0; i < 6000; i++) begin
      en = ($urandom_range(0, 199) != 0);
      if (to_next <= 1) begin
        p = 1'b1;
        case ($urandom_range(0, 9))
          0:       to_next = $urandom_range(1, 7);
          1:       to_next = $urandom_range(25, 40);
          2:       to_next = (($urandom_range(0, 1) == 0) ? MIN : MAX);
          default: to_next = $urandom_range(MIN, MAX);
        endcase
      end else begin
        p = 1'b0;
        to_next--;
      end
      step(en, p);
      checks++;
      if (link_up !== m_link || link_change !== m_lc || interval_error !== m_ie ||
          pulse_count !== 16'(m_pc) || error_count !== 16'(m_ec)) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_cycle%0d: got up=%0b chg=%0b err=%0b pc=%0d ec=%0d expected up=%0b chg=%0b err=%0b pc=%0d ec=%0d",
                   i, link_up, link_change, interval_error, pulse_count, error_count,
                   m_link, m_lc, m_ie, m_pc, m_ec);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_acquire();
    test_timeout();
    test_window_edges();
    test_early_up();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
